ether_import: RTL and testbench

- RMII receive-side counterpart of the frame exporter.
- Consumes 2-bit RMII dibits, detects preamble/SFD and parses the team's frame protocol: a frame-start message, then one message per row.
- Writes 4-bit grayscale pixels into a framebuffer BRAM write port.
- Sits between the Ethernet PHY RX pins and the display framebuffer; reports row, frame and error events to the display controller.

---
 rtl/ether_import.sv | 220 ++++++++++++++++++++++
 tb/tb_ether_import.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ether_import.sv
// RMII receive path: finds preamble/SFD, parses frame-start and row messages,
// and streams 4-bit grayscale pixels into a framebuffer BRAM write port.
module ether_import #(
    parameter int DISPLAY_WIDTH  = 320,
    parameter int DISPLAY_HEIGHT = 240,
    parameter int H_BITS         = 9,
    parameter int ADDR_BITS      = 17,
    parameter int PREAMBLE_MIN   = 8
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic                 eth_crsdv,
    input  logic [1:0]           eth_rxd,
    output logic [ADDR_BITS-1:0] write_addr_out,
    output logic [3:0]           write_data_out,
    output logic                 write_en_out,
    output logic                 frame_start_out,
    output logic                 row_done_out,
    output logic                 frame_done_out,
    output logic                 error_out,
    output logic                 busy_out
);

    localparam int COL_W = ($clog2(DISPLAY_WIDTH) > 0) ? $clog2(DISPLAY_WIDTH) : 1;
    localparam int ROW_W = ($clog2(DISPLAY_HEIGHT) > 0) ? $clog2(DISPLAY_HEIGHT) : 1;
    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(DISPLAY_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(DISPLAY_HEIGHT - 1);
    localparam logic [15:0]      HEIGHT_16 = 16'(DISPLAY_HEIGHT);
    localparam logic [7:0]       PRE_MIN_8 = 8'(PREAMBLE_MIN);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PREAMBLE = 3'd1,
        HEADER   = 3'd2,
        PIXELS   = 3'd3,
        DROP     = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic                   crs_q;
    logic [1:0]             rxd_q;
    logic [7:0]             pre_cnt_q, pre_cnt_d;
    logic [2:0]             hdr_cnt_q, hdr_cnt_d;
    logic [15:0]            hdr_q, hdr_d;
    logic [15:0]            hdr_next_s;
    logic [ROW_W-1:0]       row_q, row_d;
    logic [COL_W-1:0]       col_q, col_d;
    logic                   phase_q, phase_d;
    logic [1:0]             hi_q, hi_d;
    logic [ADDR_BITS-1:0]   write_addr_q, write_addr_d;
    logic [3:0]             write_data_q, write_data_d;
    logic                   write_en_q, write_en_d;
    logic                   frame_start_q, frame_start_d;
    logic                   row_done_q, row_done_d;
    logic                   frame_done_q, frame_done_d;
    logic                   error_q, error_d;
    logic                   busy_q, busy_d;

    // Next-state and output decode; acts only on the registered RMII inputs.
    always_comb begin
        state_d       = state_q;
        pre_cnt_d     = pre_cnt_q;
        hdr_cnt_d     = hdr_cnt_q;
        hdr_d         = hdr_q;
        row_d         = row_q;
        col_d         = col_q;
        phase_d       = phase_q;
        hi_d          = hi_q;
        write_addr_d  = write_addr_q;
        write_data_d  = write_data_q;
        write_en_d    = 1'b0;
        frame_start_d = 1'b0;
        row_done_d    = 1'b0;
        frame_done_d  = 1'b0;
        error_d       = 1'b0;
        hdr_next_s    = {rxd_q, hdr_q[15:2]};

        case (state_q)
            IDLE: begin
                if (crs_q) begin
                    if (rxd_q == 2'b01) begin
                        state_d   = PREAMBLE;
                        pre_cnt_d = 8'd1;
                    end else begin
                        state_d = DROP;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            PREAMBLE: begin
                if (!crs_q) begin
                    state_d = IDLE;
                end else if (rxd_q == 2'b01) begin
                    if (pre_cnt_q != 8'hFF) begin
                        pre_cnt_d = pre_cnt_q + 8'd1;
                    end else begin
                        pre_cnt_d = pre_cnt_q;
                    end
                end else if ((rxd_q == 2'b11) && (pre_cnt_q >= PRE_MIN_8)) begin
                    state_d   = HEADER;
                    hdr_cnt_d = 3'd0;
                end else begin
                    state_d = DROP;
                end
            end
            HEADER: begin
                if (!crs_q) begin
                    error_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    // Right shift leaves the first dibit in hdr[1:0] after eight steps.
                    hdr_d = hdr_next_s;
                    if (hdr_cnt_q == 3'd7) begin
                        if (hdr_next_s == 16'hFFFF) begin
                            frame_start_d = 1'b1;
                            state_d       = DROP;
                        end else if (hdr_next_s < HEIGHT_16) begin
                            row_d   = ROW_W'(hdr_next_s);
                            col_d   = {COL_W{1'b0}};
                            phase_d = 1'b0;
                            state_d = PIXELS;
                        end else begin
                            error_d = 1'b1;
                            state_d = DROP;
                        end
                    end else begin
                        hdr_cnt_d = hdr_cnt_q + 3'd1;
                    end
                end
            end
            PIXELS: begin
                if (!crs_q) begin
                    error_d = 1'b1;
                    state_d = IDLE;
                end else if (!phase_q) begin
                    hi_d    = rxd_q;
                    phase_d = 1'b1;
                end else begin
                    write_en_d   = 1'b1;
                    write_data_d = {hi_q, rxd_q};
                    write_addr_d = ADDR_BITS'((32'(row_q) << H_BITS) + 32'(col_q));
                    phase_d      = 1'b0;
                    if (col_q == COL_LAST) begin
                        row_done_d   = 1'b1;
                        frame_done_d = (row_q == ROW_LAST);
                        state_d      = DROP;
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                end
            end
            DROP: begin
                if (!crs_q) begin
                    state_d = IDLE;
                end else begin
                    state_d = DROP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // Input capture plus all FSM, counter and output registers.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            crs_q         <= 1'b0;
            rxd_q         <= 2'b00;
            state_q       <= IDLE;
            pre_cnt_q     <= 8'd0;
            hdr_cnt_q     <= 3'd0;
            hdr_q         <= 16'd0;
            row_q         <= {ROW_W{1'b0}};
            col_q         <= {COL_W{1'b0}};
            phase_q       <= 1'b0;
            hi_q          <= 2'b00;
            write_addr_q  <= {ADDR_BITS{1'b0}};
            write_data_q  <= 4'd0;
            write_en_q    <= 1'b0;
            frame_start_q <= 1'b0;
            row_done_q    <= 1'b0;
            frame_done_q  <= 1'b0;
            error_q       <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            crs_q         <= eth_crsdv;
            rxd_q         <= eth_rxd;
            state_q       <= state_d;
            pre_cnt_q     <= pre_cnt_d;
            hdr_cnt_q     <= hdr_cnt_d;
            hdr_q         <= hdr_d;
            row_q         <= row_d;
            col_q         <= col_d;
            phase_q       <= phase_d;
            hi_q          <= hi_d;
            write_addr_q  <= write_addr_d;
            write_data_q  <= write_data_d;
            write_en_q    <= write_en_d;
            frame_start_q <= frame_start_d;
            row_done_q    <= row_done_d;
            frame_done_q  <= frame_done_d;
            error_q       <= error_d;
            busy_q        <= busy_d;
        end
    end

    assign write_addr_out  = write_addr_q;
    assign write_data_out  = write_data_q;
    assign write_en_out    = write_en_q;
    assign frame_start_out = frame_start_q;
    assign row_done_out    = row_done_q;
    assign frame_done_out  = frame_done_q;
    assign error_out       = error_q;
    assign busy_out        = busy_q;

endmodule

// File: tb/tb_ether_import.sv
// Scoreboard bench for ether_import: expected BRAM writes are queued as pixels
// are driven and matched against write strobes; event pulses are counted per message.
module tb_ether_import;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int HB = 2;
    localparam int AB = 4;

    logic          clk;
    logic          rst_n;
    logic          crsdv;
    logic [1:0]    rxd;
    logic [AB-1:0] waddr;
    logic [3:0]    wdata;
    logic          wen, fstart, rdone, fdone, err, busy;

    ether_import #(
        .DISPLAY_WIDTH (W),
        .DISPLAY_HEIGHT(H),
        .H_BITS        (HB),
        .ADDR_BITS     (AB),
        .PREAMBLE_MIN  (8)
    ) dut (
        .clk_in         (clk),
        .rst_n_in       (rst_n),
        .eth_crsdv      (crsdv),
        .eth_rxd        (rxd),
        .write_addr_out (waddr),
        .write_data_out (wdata),
        .write_en_out   (wen),
        .frame_start_out(fstart),
        .row_done_out   (rdone),
        .frame_done_out (fdone),
        .error_out      (err),
        .busy_out       (busy)
    );

    typedef struct packed {
        logic [3:0] addr;
        logic [3:0] data;
        logic       rd;
        logic       fd;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;
    int   cyc    = 0;
    int   fs_cnt = 0, rd_cnt = 0, fd_cnt = 0, err_cnt = 0, wr_cnt = 0;
    int   b_fs, b_rd, b_fd, b_err, b_wr;
    int   fs_cyc = 0;
    int   hdr_end_cyc;

    initial clk = 1'b0;
    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Output monitor: scoreboard pops on each write, pulses are tallied.
    always @(negedge clk) begin
        if (fstart) begin
            fs_cnt++;
            fs_cyc = cyc;
        end
        if (rdone) rd_cnt++;
        if (fdone) fd_cnt++;
        if (err)   err_cnt++;
        if (wen) begin
            exp_t e;
            wr_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_write", 32'(waddr), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", 32'(waddr), 32'(e.addr));
                check("wr_data", 32'(wdata), 32'(e.data));
                check("wr_row_done", 32'(rdone), 32'(e.rd));
                check("wr_frame_done", 32'(fdone), 32'(e.fd));
            end
        end
    end

    task automatic send(input logic c, input logic [1:0] d);
        @(posedge clk);
        #1;
        crsdv = c;
        rxd   = d;
    endtask

    task automatic idle(input int n);
        repeat (n) send(1'b0, 2'b00);
    endtask

    task automatic preamble(input int n);
        repeat (n) send(1'b1, 2'b01);
        send(1'b1, 2'b11);
    endtask

    task automatic header(input logic [15:0] h);
        for (int k = 0; k < 8; k++) send(1'b1, h[2*k +: 2]);
        hdr_end_cyc = cyc;
    endtask

    task automatic pixel(input logic [3:0] addr, input logic [3:0] val,
                         input logic rd, input logic fd);
        exp_t e;
        e.addr = addr;
        e.data = val;
        e.rd   = rd;
        e.fd   = fd;
        exp_q.push_back(e);
        send(1'b1, val[3:2]);
        send(1'b1, val[1:0]);
    endtask

    task automatic mark();
        b_fs = fs_cnt; b_rd = rd_cnt; b_fd = fd_cnt; b_err = err_cnt; b_wr = wr_cnt;
    endtask

    task automatic expect_counts(input string tag, input int fs, input int rd,
                                 input int fd, input int er, input int wr);
        check({tag, "_frame_start"}, 32'(fs_cnt - b_fs), 32'(fs));
        check({tag, "_row_done"},    32'(rd_cnt - b_rd), 32'(rd));
        check({tag, "_frame_done"},  32'(fd_cnt - b_fd), 32'(fd));
        check({tag, "_error"},       32'(err_cnt - b_err), 32'(er));
        check({tag, "_writes"},      32'(wr_cnt - b_wr), 32'(wr));
        check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_busy_idle"},   32'(busy), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        crsdv = 1'b0;
        rxd   = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_outputs", {20'd0, wen, fstart, rdone, fdone, err, busy, waddr, wdata},
              32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // Frame-start: header FFFF followed by ignored trailer
        mark();
        repeat (28) send(1'b1, 2'b01);
        send(1'b1, 2'b11);
        header(16'hFFFF);
        repeat (92) send(1'b1, 2'b11);
        idle(5);
        expect_counts("fstart", 1, 0, 0, 0, 0);
        check("fstart_latency", 32'(fs_cyc - hdr_end_cyc), 32'd2);

        // Row 2, the last row, completes the frame
        mark();
        preamble(8);
        header(16'd2);
        pixel(4'd8,  4'hA, 1'b0, 1'b0);
        pixel(4'd9,  4'h3, 1'b0, 1'b0);
        pixel(4'd10, 4'hF, 1'b0, 1'b0);
        pixel(4'd11, 4'h0, 1'b1, 1'b1);
        repeat (6) send(1'b1, 2'b10);
        idle(5);
        expect_counts("row2", 0, 1, 1, 0, 4);

        // Truncation after pixel 1 high dibit
        mark();
        preamble(10);
        header(16'd1);
        pixel(4'd4, 4'h6, 1'b0, 1'b0);
        send(1'b1, 2'b01);
        send(1'b0, 2'b00);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        check("trunc_busy_1cyc", 32'(busy), 32'd1);
        @(posedge clk);
        @(negedge clk);
        check("trunc_busy_2cyc", 32'(busy), 32'd0);
        idle(4);
        expect_counts("trunc", 0, 0, 0, 1, 1);

        // Out-of-range row, then a valid row 0
        mark();
        preamble(8);
        header(16'd5);
        repeat (8) send(1'b1, 2'b01);
        idle(4);
        expect_counts("badhdr", 0, 0, 0, 1, 0);
        mark();
        preamble(8);
        header(16'd0);
        pixel(4'd0, 4'h1, 1'b0, 1'b0);
        pixel(4'd1, 4'h7, 1'b0, 1'b0);
        pixel(4'd2, 4'hC, 1'b0, 1'b0);
        pixel(4'd3, 4'h9, 1'b1, 1'b0);
        idle(5);
        expect_counts("row0", 0, 1, 0, 0, 4);

        // Short preamble: whole message must be ignored
        mark();
        preamble(4);
        header(16'd1);
        repeat (8) send(1'b1, 2'b10);
        idle(5);
        expect_counts("shortpre", 0, 0, 0, 0, 0);

        // Reset mid-row after two writes
        mark();
        preamble(8);
        header(16'd0);
        pixel(4'd0, 4'h5, 1'b0, 1'b0);
        pixel(4'd1, 4'h6, 1'b0, 1'b0);
        send(1'b1, 2'b10);
        @(posedge clk);
        @(negedge clk);
        #1;
        check("pre_reset_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_rst_outputs", {20'd0, wen, fstart, rdone, fdone, err, busy, waddr, wdata},
              32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        send(1'b1, 2'b01);
        send(1'b1, 2'b11);
        send(1'b1, 2'b00);
        idle(5);
        expect_counts("reset", 0, 0, 0, 0, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

endmodule
